// File: rtl/systolic_psum_drain_pkg.sv
// Shared types and defaults for the systolic array output drain.
//   INT_BITS      : default width of one partial-sum lane
//   ROW_W         : width of one aligned result row (three lanes)
//   drain_state_t : drain controller states
package systolic_pkg;

    localparam int unsigned INT_BITS = 13;
    localparam int unsigned ROW_W    = 3 * INT_BITS;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FLUSH   = 2'd2
    } drain_state_t;

endpackage

// File: rtl/systolic_psum_drain_if.sv
// Result-row handshake towards the writeback path.
//   out_valid : a row is presented
//   out_ready : consumer accepts the row
//   out_data  : {psum2, psum1, psum0}, column 0 in the LSBs
//   out_last  : presented row is the final row of the tile
// master = drain (producer), slave = writeback (consumer).
interface systolic_psum_drain_if
    import systolic_pkg::*;
#(
    parameter int unsigned ROW_W = systolic_pkg::ROW_W
);
    logic             out_valid;
    logic             out_ready;
    logic [ROW_W-1:0] out_data;
    logic             out_last;

    modport master (output out_valid, output out_data, output out_last, input  out_ready);
    modport slave  (input  out_valid, input  out_data, input  out_last, output out_ready);

endinterface

// File: rtl/systolic_psum_drain_row_fifo.sv
// Synchronous result-row FIFO with occupancy count.
//   clk, reset (sync, active-low) ; push/din write ; pop/dout read (show-ahead)
//   full, empty, count : occupancy status
// A push on a full FIFO succeeds only when a pop happens in the same cycle.
module psum_row_fifo #(
    parameter  int unsigned WIDTH = systolic_pkg::ROW_W,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Storage needs no reset: dout is masked by the consumer while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/systolic_psum_drain.sv
// Drains the column-skewed bottom-row partial sums of the 3x3 systolic array.
//   clk, reset        : clock, synchronous active-low reset
//   start, n_rows     : arm a tile of n_rows result rows (n_rows==0 is a no-op)
//   col0_valid        : psum0 valid now; psum1/psum2 of the same row follow at +1/+2
//   psum0..psum2      : array column outputs
//   almost_full       : FIFO holds >= FIFO_DEPTH-2 rows, feeder must pause
//   busy, done        : tile in progress / one-cycle pulse when the tile finishes
//   overflow          : sticky, a row was dropped on a full FIFO
//   wb                : row handshake to writeback
module systolic_psum_drain
    import systolic_pkg::*;
#(
    parameter int unsigned int_bits   = INT_BITS,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [CNT_W-1:0]     n_rows,
    input  logic                 col0_valid,
    input  logic [int_bits-1:0]  psum0,
    input  logic [int_bits-1:0]  psum1,
    input  logic [int_bits-1:0]  psum2,
    output logic                 almost_full,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    systolic_psum_drain_if.master wb
);

    localparam int unsigned RW = 3 * int_bits;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t         state_q;
    drain_state_t         state_d;
    logic [CNT_W-1:0]     n_rows_q;
    logic [CNT_W-1:0]     pushed_cnt;
    logic [CNT_W-1:0]     popped_cnt;
    logic [int_bits-1:0]  p0_d1;
    logic [int_bits-1:0]  p0_d2;
    logic [int_bits-1:0]  p1_d1;
    logic                 v_d1;
    logic                 v_d2;
    logic                 done_q;
    logic                 overflow_q;

    logic                 gate_in;
    logic                 arm;
    logic                 done_set;
    logic                 row_valid;
    logic                 row_last;
    logic                 pop;
    logic                 drop;
    logic [RW-1:0]        row;
    logic [RW-1:0]        fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

    // Rows are admitted at the skew-pipe entry so in-flight rows always complete.
    assign gate_in   = col0_valid & (state_q == COLLECT) & (pushed_cnt < n_rows_q);
    assign row       = {psum2, p1_d1, p0_d2};
    assign row_valid = ~fifo_empty;
    assign row_last  = row_valid & (popped_cnt == n_rows_q - CNT_W'(1));
    assign pop       = row_valid & wb.out_ready;
    assign drop      = v_d2 & fifo_full & ~pop;

    psum_row_fifo #(
        .WIDTH (RW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (v_d2),
        .pop   (pop),
        .din   (row),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state and tile control.
    always_comb begin
        state_d  = state_q;
        arm      = 1'b0;
        done_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_rows != '0) begin
                        state_d = COLLECT;
                        arm     = 1'b1;
                    end else begin
                        done_set = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (pushed_cnt == n_rows_q) state_d = FLUSH;
            end
            FLUSH: begin
                if (pop && row_last) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, deskew pipe, counters and flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            n_rows_q   <= '0;
            pushed_cnt <= '0;
            popped_cnt <= '0;
            p0_d1      <= '0;
            p0_d2      <= '0;
            p1_d1      <= '0;
            v_d1       <= 1'b0;
            v_d2       <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_set;
            v_d1    <= gate_in;
            v_d2    <= v_d1;
            p0_d1   <= psum0;
            p0_d2   <= p0_d1;
            p1_d1   <= psum1;
            if (drop) overflow_q <= 1'b1;
            if (arm) begin
                n_rows_q   <= n_rows;
                pushed_cnt <= '0;
                popped_cnt <= '0;
            end else begin
                if (gate_in) pushed_cnt <= pushed_cnt + CNT_W'(1);
                if (pop)     popped_cnt <= popped_cnt + CNT_W'(1);
            end
        end
    end

    assign almost_full  = (fifo_count >= CW'(FIFO_DEPTH - 2));
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign overflow     = overflow_q;
    assign wb.out_valid = row_valid;
    assign wb.out_last  = row_last;
    assign wb.out_data  = row_valid ? fifo_dout : '0;

endmodule
